// File: rtl/synchronous_fifo_pkg.sv
// rtl/synchronous_fifo_pkg.sv - shared defaults and sizing helper for synchronous_fifo
package synchronous_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;

  // Occupancy counter must hold 0..depth inclusive, hence one bit above the pointer width
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH register array, sync write port, registered read port
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately left out of reset; only words that were written are ever read
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read word is captured on the accepting edge and held until the next accepted read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/synchronous_fifo.sv
// rtl/synchronous_fifo.sv - single-clock FIFO with counter-based flags; optional SYNC_FIFO_ERR_FLAGS_EN
module synchronous_fifo
  import synchronous_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_acc;
  logic             rd_acc;

  // Flags decode straight from the registered count so they never glitch within a cycle
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  // Next-state for pointers and occupancy; simultaneous accepted push and pop cancel out
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers, discarded immediately on reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags: any request that had to be dropped is remembered until reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (w_en && full) begin
        overflow_q <= 1'b1;
      end
      if (r_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_synchronous_fifo.sv
// tb/tb_synchronous_fifo.sv - directed self-checking bench for synchronous_fifo
module tb_synchronous_fifo;

  logic       clk;
  logic       rst_n;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks   = 0;
  int failures = 0;

  synchronous_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_en      (w_en),
    .r_en      (r_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    w_en = 1'b1; r_en = 1'b0; data_in = d;
    step();
    w_en = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    r_en = 1'b1; w_en = 1'b0;
    step();
    r_en = 1'b0;
    chk(tag, {24'h0, data_out}, {24'h0, exp});
  endtask

  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int         mcnt;
  int         nwr;
  bit         w_acc;
  bit         r_acc;

  initial begin
    rst_n = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;

    // Reset held for 10 cycles
    repeat (10) step();
    rst_n = 1'b0;
    step();
    chk("reset_empty", {31'h0, empty}, 32'h1);
    chk("reset_full", {31'h0, full}, 32'h0);
    chk("reset_data_out", {24'h0, data_out}, 32'h0);

    // Asynchronous reset between edges clears occupancy at once
    push(8'h5A);
    push(8'h5B);
    chk("pre_async_empty", {31'h0, empty}, 32'h0);
    #2 rst_n = 1'b1;
    #1 chk("async_rst_empty", {31'h0, empty}, 32'h1);
    step();
    rst_n = 1'b0;
    step();

    // Fill and drain
    for (int i = 1; i <= 8; i++) begin
      push(8'((i << 4) | i));
      chk("fill_full", {31'h0, full}, (i == 8) ? 32'h1 : 32'h0);
    end
    push(8'hFF);
    chk("ovf_write_full", {31'h0, full}, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      pop_chk("drain_data", 8'((i << 4) | i));
    end
    chk("drain_empty", {31'h0, empty}, 32'h1);
    pop_chk("read_empty_hold", 8'h88);

    // Simultaneous read and write at count=4
    for (int i = 1; i <= 4; i++) push(8'hA0 + 8'(i));
    w_en = 1'b1; r_en = 1'b1; data_in = 8'hA5;
    step();
    w_en = 1'b0; r_en = 1'b0;
    chk("rw4_data", {24'h0, data_out}, 32'hA1);
    chk("rw4_full", {31'h0, full}, 32'h0);
    pop_chk("rw4_d2", 8'hA2);
    pop_chk("rw4_d3", 8'hA3);
    pop_chk("rw4_d4", 8'hA4);
    chk("rw4_not_empty", {31'h0, empty}, 32'h0);
    pop_chk("rw4_d5", 8'hA5);
    chk("rw4_empty", {31'h0, empty}, 32'h1);

    // Simultaneous read and write while full: only the read happens
    for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
    chk("rwf_full_before", {31'h0, full}, 32'h1);
    w_en = 1'b1; r_en = 1'b1; data_in = 8'hFF;
    step();
    w_en = 1'b0; r_en = 1'b0;
    chk("rwf_data", {24'h0, data_out}, 32'hB0);
    chk("rwf_full_after", {31'h0, full}, 32'h0);
    for (int i = 1; i < 8; i++) pop_chk("rwf_drain", 8'hB0 + 8'(i));
    chk("rwf_empty", {31'h0, empty}, 32'h1);

    // Simultaneous read and write while empty: only the write happens, no bypass
    w_en = 1'b1; r_en = 1'b1; data_in = 8'hC0;
    step();
    w_en = 1'b0; r_en = 1'b0;
    chk("rwe_data_hold", {24'h0, data_out}, 32'hB7);
    chk("rwe_not_empty", {31'h0, empty}, 32'h0);
    pop_chk("rwe_word", 8'hC0);
    chk("rwe_empty", {31'h0, empty}, 32'h1);

    // Alternating traffic against a scoreboard and occupancy model
    mcnt = 0; nwr = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      w_en = ((cyc % 2) == 0) && (nwr < 30);
      r_en = (cyc >= 10) && ((cyc % 2) == 0);
      data_in = 8'($urandom_range(0, 255));
      w_acc = w_en && (mcnt < 8);
      r_acc = r_en && (mcnt > 0);
      step();
      if (r_acc) begin
        exp_b = sb.pop_front();
        chk("alt_data", {24'h0, data_out}, {24'h0, exp_b});
      end
      if (w_acc) begin
        sb.push_back(data_in);
        nwr++;
      end
      mcnt = mcnt + (w_acc ? 1 : 0) - (r_acc ? 1 : 0);
      chk("alt_empty", {31'h0, empty}, (mcnt == 0) ? 32'h1 : 32'h0);
      chk("alt_full", {31'h0, full}, (mcnt == 8) ? 32'h1 : 32'h0);
    end
    w_en = 1'b0; r_en = 1'b0;
    chk("alt_all_written", nwr, 30);
    chk("alt_sb_drained", sb.size(), 0);

    // Wrap-around: three rounds of six writes and six reads
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) push(8'(8'h40 + r * 16 + i));
      for (int i = 0; i < 6; i++) pop_chk("wrap_data", 8'(8'h40 + r * 16 + i));
      chk("wrap_empty", {31'h0, empty}, 32'h1);
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk("err_rst_ovf", {31'h0, overflow}, 32'h0);
    chk("err_rst_udf", {31'h0, underflow}, 32'h0);
    for (int i = 0; i < 8; i++) push(8'(i));
    chk("err_no_ovf_yet", {31'h0, overflow}, 32'h0);
    push(8'hEE);
    chk("err_ovf_set", {31'h0, overflow}, 32'h1);
    pop_chk("err_pop", 8'h00);
    chk("err_ovf_sticky", {31'h0, overflow}, 32'h1);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk("err_ovf_clr", {31'h0, overflow}, 32'h0);
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    chk("err_udf_set", {31'h0, underflow}, 32'h1);
    step();
    chk("err_udf_sticky", {31'h0, underflow}, 32'h1);
    rst_n = 1'b1;
    #1 chk("err_udf_clr", {31'h0, underflow}, 32'h0);
    step();
    rst_n = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
